// File: rtl/axi_s2m_pkg.sv
// Shared defaults and skid-buffer state encoding for the slave-to-master
// response mux (B and R channels).
package axi_s2m_pkg;

    localparam int NUM_DEF    = 3;
    localparam int W_ID_DEF   = 4;
    localparam int W_DATA_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/axi_skid_s2m.sv
// Two-entry skid buffer (main + skid register) with a registered ready path.
// The master side is always driven from the main register; the skid register
// only catches the beat that arrives while main is still waiting to drain.
module axi_skid_s2m
    import axi_s2m_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state;
    buf_state_t   state_nxt;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         drain;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;

    // Ready is forced low while reset is held so no slave sees a handshake.
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Next-state and register-load decisions for the three-state buffer.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (drain && !accept) begin
                    state_nxt = EMPTY;
                end else if (accept && drain) begin
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (drain) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State register; reset discards any buffered beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Main register is cleared on reset so the master payload reads zero
    // until the first beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 main_q <= '0;
        else if (load_main_in)   main_q <= in_data;
        else if (load_main_skid) main_q <= skid_q;
    end

    // Skid register holds payload only; its contents are meaningless unless FULL.
    always_ff @(posedge clk) begin
        if (load_skid) skid_q <= in_data;
    end

endmodule

// File: rtl/axi_mux_s2m_rs.sv
// Slave-to-master B and R response mux, each channel followed by a skid buffer.
// The lowest set grant bit selects the slave; a zero grant selects nobody.
module axi_mux_s2m_rs
    import axi_s2m_pkg::*;
#(
    parameter int NUM    = NUM_DEF,
    parameter int W_ID   = W_ID_DEF,
    parameter int W_DATA = W_DATA_DEF
) (
    input  logic                    AXI_CLK,
    input  logic                    AXI_RST,
    input  logic [NUM:0]            BGRANT,
    input  logic [(NUM+1)*W_ID-1:0] S_BID,
    input  logic [(NUM+1)*2-1:0]    S_BRESP,
    input  logic [NUM:0]            S_BVALID,
    output logic [NUM:0]            S_BREADY,
    output logic [W_ID-1:0]         M_BID,
    output logic [1:0]              M_BRESP,
    output logic                    M_BVALID,
    input  logic                    M_BREADY,
    input  logic [NUM:0]            RGRANT,
    input  logic [(NUM+1)*W_ID-1:0]   S_RID,
    input  logic [(NUM+1)*W_DATA-1:0] S_RDATA,
    input  logic [(NUM+1)*2-1:0]      S_RRESP,
    input  logic [NUM:0]              S_RLAST,
    input  logic [NUM:0]              S_RVALID,
    output logic [NUM:0]              S_RREADY,
    output logic [W_ID-1:0]           M_RID,
    output logic [W_DATA-1:0]         M_RDATA,
    output logic [1:0]                M_RRESP,
    output logic                      M_RLAST,
    output logic                      M_RVALID,
    input  logic                      M_RREADY
);

    localparam int W_B = W_ID + 2;
    localparam int W_R = W_ID + W_DATA + 3;

    logic [NUM:0]   b_sel;
    logic [NUM:0]   r_sel;
    logic           b_sel_valid;
    logic           r_sel_valid;
    logic [W_B-1:0] b_sel_data;
    logic [W_R-1:0] r_sel_data;
    logic           b_in_ready;
    logic           r_in_ready;
    logic [W_B-1:0] b_out_data;
    logic [W_R-1:0] r_out_data;

    // x & -x isolates the lowest set bit, so a multi-bit grant degrades to
    // the lowest index instead of OR-ing several slaves together.
    assign b_sel = BGRANT & (~BGRANT + (NUM+1)'(1));
    assign r_sel = RGRANT & (~RGRANT + (NUM+1)'(1));

    assign S_BREADY = b_sel & {(NUM+1){b_in_ready}};
    assign S_RREADY = r_sel & {(NUM+1){r_in_ready}};

    // B payload mux driven by the one-hot select.
    always_comb begin
        b_sel_valid = 1'b0;
        b_sel_data  = '0;
        for (int i = 0; i <= NUM; i++) begin
            if (b_sel[i]) begin
                b_sel_valid = S_BVALID[i];
                b_sel_data  = {S_BID[i*W_ID +: W_ID], S_BRESP[i*2 +: 2]};
            end
        end
    end

    // R payload mux driven by the one-hot select; RLAST passes through untouched.
    always_comb begin
        r_sel_valid = 1'b0;
        r_sel_data  = '0;
        for (int i = 0; i <= NUM; i++) begin
            if (r_sel[i]) begin
                r_sel_valid = S_RVALID[i];
                r_sel_data  = {S_RID[i*W_ID +: W_ID], S_RDATA[i*W_DATA +: W_DATA],
                               S_RRESP[i*2 +: 2], S_RLAST[i]};
            end
        end
    end

    axi_skid_s2m #(.W(W_B)) u_b_skid (
        .clk       (AXI_CLK),
        .rst       (AXI_RST),
        .in_valid  (b_sel_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_sel_data),
        .out_valid (M_BVALID),
        .out_ready (M_BREADY),
        .out_data  (b_out_data)
    );

    axi_skid_s2m #(.W(W_R)) u_r_skid (
        .clk       (AXI_CLK),
        .rst       (AXI_RST),
        .in_valid  (r_sel_valid),
        .in_ready  (r_in_ready),
        .in_data   (r_sel_data),
        .out_valid (M_RVALID),
        .out_ready (M_RREADY),
        .out_data  (r_out_data)
    );

    assign {M_BID, M_BRESP}                 = b_out_data;
    assign {M_RID, M_RDATA, M_RRESP, M_RLAST} = r_out_data;

endmodule

// File: tb/tb_axi_mux_s2m_rs.sv
// Bench for axi_mux_s2m_rs: directed scenarios followed by random traffic,
// all compared against a queue-based model of a two-deep response FIFO.
module tb_axi_mux_s2m_rs;

    logic         clk;
    logic         rst;
    logic [3:0]   bgrant;
    logic [15:0]  s_bid;
    logic [7:0]   s_bresp;
    logic [3:0]   s_bvalid;
    logic [3:0]   s_bready;
    logic [3:0]   m_bid;
    logic [1:0]   m_bresp;
    logic         m_bvalid;
    logic         m_bready;
    logic [3:0]   rgrant;
    logic [15:0]  s_rid;
    logic [127:0] s_rdata;
    logic [7:0]   s_rresp;
    logic [3:0]   s_rlast;
    logic [3:0]   s_rvalid;
    logic [3:0]   s_rready;
    logic [3:0]   m_rid;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         m_rvalid;
    logic         m_rready;

    int total = 0;
    int bad   = 0;

    logic [5:0]  qb[$];
    logic [38:0] qr[$];
    bit          b_seen, r_seen;
    bit          b_acc, r_acc;
    bit          rv_sample;

    axi_mux_s2m_rs dut (
        .AXI_CLK (clk),      .AXI_RST (rst),
        .BGRANT  (bgrant),   .S_BID   (s_bid),   .S_BRESP (s_bresp),
        .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .M_BID   (m_bid),    .M_BRESP (m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .RGRANT  (rgrant),   .S_RID   (s_rid),   .S_RDATA (s_rdata),  .S_RRESP (s_rresp),
        .S_RLAST (s_rlast),  .S_RVALID(s_rvalid), .S_RREADY(s_rready),
        .M_RID   (m_rid),    .M_RDATA (m_rdata), .M_RRESP (m_rresp),  .M_RLAST (m_rlast),
        .M_RVALID(m_rvalid), .M_RREADY(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic logic [5:0] bpay(input int i);
        return {s_bid[i*4 +: 4], s_bresp[i*2 +: 2]};
    endfunction

    function automatic logic [38:0] rpay(input int i);
        return {s_rid[i*4 +: 4], s_rdata[i*32 +: 32], s_rresp[i*2 +: 2], s_rlast[i]};
    endfunction

    function automatic logic [3:0] exp_ready(input logic [3:0] g, input int depth);
        int idx;
        idx = lowest(g);
        if (rst || idx < 0 || depth >= 2) return 4'd0;
        return 4'(1 << idx);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the FIFO model.
    task automatic checkOutput();
        chk("S_BREADY", 64'(s_bready), 64'(exp_ready(bgrant, qb.size())));
        chk("S_RREADY", 64'(s_rready), 64'(exp_ready(rgrant, qr.size())));
        chk("M_BVALID", 64'(m_bvalid), 64'(qb.size() > 0));
        chk("M_RVALID", 64'(m_rvalid), 64'(qr.size() > 0));
        if (qb.size() > 0)  chk("M_B_payload", 64'({m_bid, m_bresp}), 64'(qb[0]));
        else if (!b_seen)   chk("M_B_zero", 64'({m_bid, m_bresp}), 64'd0);
        if (qr.size() > 0)  chk("M_R_payload", 64'({m_rid, m_rdata, m_rresp, m_rlast}), 64'(qr[0]));
        else if (!r_seen)   chk("M_R_zero", 64'({m_rid, m_rdata, m_rresp, m_rlast}), 64'd0);
        rv_sample = m_rvalid;
    endtask

    // One clock: check mid-cycle, predict handshakes, advance the model.
    task automatic applyStimulus();
        int         bi, ri;
        bit         b_drn, r_drn;
        logic [5:0]  bp;
        logic [38:0] rp;
        #3 checkOutput();
        bi = lowest(bgrant);
        ri = lowest(rgrant);
        b_acc = !rst && bi >= 0 && s_bvalid[bi] && qb.size() < 2;
        r_acc = !rst && ri >= 0 && s_rvalid[ri] && qr.size() < 2;
        bp = b_acc ? bpay(bi) : '0;
        rp = r_acc ? rpay(ri) : '0;
        b_drn = qb.size() > 0 && m_bready;
        r_drn = qr.size() > 0 && m_rready;
        @(posedge clk);
        #1;
        if (b_drn) void'(qb.pop_front());
        if (r_drn) void'(qr.pop_front());
        if (b_acc) begin qb.push_back(bp); b_seen = 1; end
        if (r_acc) begin qr.push_back(rp); r_seen = 1; end
    endtask

    task automatic idleInputs();
        bgrant = 0; s_bvalid = 0; m_bready = 1;
        rgrant = 0; s_rvalid = 0; m_rready = 1;
    endtask

    initial begin
        int k, first, last, cnt;
        rst = 1;
        bgrant = 4'hF; rgrant = 4'hF; s_bvalid = 4'hF; s_rvalid = 4'hF;
        m_bready = 1; m_rready = 1;
        s_bid = '1; s_bresp = '1; s_rid = '1; s_rdata = '1; s_rresp = '1; s_rlast = '1;
        b_seen = 0; r_seen = 0;

        // Reset state with grants and valids asserted
        #3 checkOutput();
        @(posedge clk); #1 checkOutput();
        @(posedge clk); #1;
        idleInputs();
        rst = 0;
        applyStimulus();

        // Single B beat from slave 2 with id 3
        bgrant = 4'b0100; s_bvalid = 4'b0100;
        s_bid[8 +: 4] = 4'd3; s_bresp[4 +: 2] = 2'd0; m_bready = 1;
        applyStimulus();
        chk("b_slave2_accepted", 64'(b_acc), 64'd1);
        s_bvalid = 0;
        applyStimulus();
        chk("b_bid_next_cycle", 64'(m_bid), 64'd3);
        applyStimulus();

        // R burst from slave 1 with master stalled for the first cycles
        idleInputs();
        rgrant = 4'b0010; k = 1;
        for (int s = 0; s < 20 && (k <= 4 || qr.size() > 0); s++) begin
            m_rready = (s >= 4);
            s_rvalid = (k <= 4) ? 4'b0010 : 4'b0000;
            s_rid[4 +: 4] = 4'(k); s_rdata[32 +: 32] = 32'(k);
            s_rresp[2 +: 2] = 2'(k); s_rlast[1] = (k == 4);
            applyStimulus();
            if (r_acc) k++;
            if (s == 1) begin
                #1;
                chk("r_full_no_ready", 64'(s_rready[1]), 64'd0);
                chk("r_hold_data1", 64'(m_rdata), 64'd1);
            end
        end
        chk("r_burst_done", 64'(k), 64'd5);

        // Sustained throughput on slave 0 for sixteen beats
        idleInputs();
        rgrant = 4'b0001;
        first = -1; last = -1; cnt = 0;
        for (int s = 0; s < 19; s++) begin
            s_rvalid = (s < 16) ? 4'b0001 : 4'b0000;
            s_rid[3:0] = 4'(s); s_rdata[31:0] = 32'hA500 + 32'(s); s_rlast[0] = (s == 15);
            applyStimulus();
            if (rv_sample) begin
                cnt++;
                if (first < 0) first = s;
                last = s;
            end
        end
        chk("r_stream_count", 64'(cnt), 64'd16);
        chk("r_stream_span", 64'(last - first + 1), 64'd16);

        // Multi-bit grant: lowest index wins
        idleInputs();
        rgrant = 4'b1010; s_rvalid = 4'b1010;
        s_rdata[32 +: 32] = 32'h1111_1111; s_rdata[96 +: 32] = 32'h3333_3333;
        for (int s = 0; s < 4; s++) applyStimulus();
        s_rvalid = 0;
        for (int s = 0; s < 3; s++) applyStimulus();

        // Grant moves from slave 0 to slave 3 while slave-0 beat is buffered
        idleInputs();
        m_bready = 0;
        bgrant = 4'b0001; s_bvalid = 4'b0001; s_bid[3:0] = 4'd5; s_bresp[1:0] = 2'd1;
        applyStimulus();
        bgrant = 4'b1000; s_bvalid = 4'b1000; s_bid[12 +: 4] = 4'd9; s_bresp[6 +: 2] = 2'd2;
        applyStimulus();
        s_bvalid = 0; m_bready = 1;
        applyStimulus();
        chk("b_second_is_slave3", 64'(m_bid), 64'd9);
        applyStimulus();

        // Mid-cycle reset with a full B buffer
        idleInputs();
        m_bready = 0; bgrant = 4'b0001; s_bvalid = 4'b0001;
        applyStimulus();
        applyStimulus();
        chk("b_full_depth", 64'(qb.size()), 64'd2);
        #2 rst = 1;
        #1;
        qb.delete(); qr.delete(); b_seen = 0; r_seen = 0;
        checkOutput();
        @(posedge clk); #1;
        idleInputs();
        bgrant = 4'b0001; rst = 0;
        for (int s = 0; s < 3; s++) applyStimulus();
        s_bvalid = 4'b0001; s_bid[3:0] = 4'd7;
        applyStimulus();
        s_bvalid = 0;
        applyStimulus();

        // Random traffic
        for (int s = 0; s < 400; s++) begin
            bgrant = 4'($urandom_range(0, 15)); rgrant = 4'($urandom_range(0, 15));
            s_bvalid = 4'($urandom); s_rvalid = 4'($urandom);
            s_bid = 16'($urandom); s_bresp = 8'($urandom);
            s_rid = 16'($urandom); s_rresp = 8'($urandom); s_rlast = 4'($urandom);
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            m_bready = 1'($urandom); m_rready = 1'($urandom);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_mux_s2m_rs.md
AXI_MUX_S2M_RS -- requirements
Module: axi_mux_s2m_rs

Interface
REQ-001 Parameter NUM, default 3, meaning highest slave index; NUM+1 slave ports indexed NUM:0.
REQ-002 Parameter W_ID, default 4, meaning AXI ID width.
REQ-003 Parameter W_DATA, default 32, meaning R data width.
REQ-004 AXI_CLK  input  1  single clock for all logic.
REQ-005 AXI_RST  input  1  asynchronous, active-high reset.
REQ-006 BGRANT  input  NUM+1  write-response grant from the s2m arbiter; one-hot or zero.
REQ-007 S_BID/S_BRESP  input  (NUM+1)*W_ID / (NUM+1)*2  slave B payloads, packed; slave i occupies slice i.
REQ-008 S_BVALID  input  NUM+1;  S_BREADY  output  NUM+1.
REQ-009 M_BID/M_BRESP/M_BVALID  output  W_ID/2/1;  M_BREADY  input  1.
REQ-010 RGRANT  input  NUM+1  read-data grant from the s2m arbiter; one-hot or zero.
REQ-011 S_RID/S_RDATA/S_RRESP/S_RLAST  input  packed per slave, widths W_ID/W_DATA/2/1 per slice.
REQ-012 S_RVALID  input  NUM+1;  S_RREADY  output  NUM+1.
REQ-013 M_RID/M_RDATA/M_RRESP/M_RLAST/M_RVALID  output;  M_RREADY  input  1.

Function
REQ-014 Each channel (B, R) SHALL contain an independent mux feeding a 2-entry skid buffer (main + skid register).
REQ-015 Mux select SHALL be the granted index; if GRANT has more than one bit set, the lowest set index SHALL win; if GRANT is zero, no slave is selected.
REQ-016 S_xREADY[i] SHALL equal GRANT[i] AND (buffer state != FULL); never asserted for a non-granted slave.
REQ-017 Accept occurs when S_xVALID[sel] AND S_xREADY[sel] are both high at a rising edge.
REQ-018 Buffer FSM states: EMPTY, ONE, FULL.
REQ-019 EMPTY: accept -> ONE (payload into main).
REQ-020 ONE: accept without drain -> FULL (payload into skid); drain without accept -> EMPTY; both -> ONE (new payload into main).
REQ-021 FULL: drain -> ONE (skid moves to main); no accept possible in FULL.
REQ-022 Drain = M_xVALID AND M_xREADY.
REQ-023 M_xVALID SHALL be high exactly in ONE and FULL; master payload driven only from main register.
REQ-024 Latency: accepted beat SHALL appear on master outputs the cycle after acceptance when buffer was EMPTY.
REQ-025 Beat order SHALL be preserved; no beat duplicated or dropped.
REQ-026 Master payload SHALL remain stable while M_xVALID high and M_xREADY low.
REQ-027 Throughput: with M_xREADY held high and continuous valid slave, one beat per cycle sustained.
REQ-028 Grant change while buffer is non-empty is legal; buffered beats drain unaffected.
REQ-029 R channel SHALL carry RLAST through unmodified; no burst tracking in this block.

Reset
REQ-030 On AXI_RST high, asynchronously: both FSMs EMPTY, M_BVALID=0, M_RVALID=0, S_BREADY=0, S_RREADY=0.
REQ-031 Payload registers need no reset; master payload outputs SHALL read zero after reset until first accept.
REQ-032 Reset mid-transfer discards buffered beats; no outputs toggle until first post-reset accept.

Structure
REQ-033 Shared package axi_s2m_pkg SHALL hold NUM/W_ID/W_DATA defaults and FSM state encodings (EMPTY=0, ONE=1, FULL=2).
REQ-034 One sub-module axi_skid_s2m (parameterised payload width) SHALL implement REQ-018..REQ-026, instantiated once for B (W_ID+2) and once for R (W_ID+W_DATA+3).

Verification
REQ-035 BGRANT=4'b0100, S_BVALID[2]=1, BID=3, BRESP=0, M_BREADY=1 -> M_BVALID=1, M_BID=3 next cycle; S_BREADY[2] high throughout.
REQ-036 RGRANT=4'b0010, 4-beat burst RDATA=1..4, M_RREADY low 3 cycles from beat 1 -> state FULL, S_RREADY[1]=0, M_RDATA held 1; on release, data 1,2,3,4 in order, RLAST only with 4.
REQ-037 M_RREADY=1, continuous RVALID on slave 0 for 16 beats -> 16 M_RVALID cycles back-to-back, ids/data match.
REQ-038 RGRANT=4'b1010 -> only slave 1 sees S_RREADY; slave 3 payload never on master.
REQ-039 AXI_RST asserted mid-cycle with FULL B buffer -> M_BVALID and S_BREADY drop immediately; after release, no beat emitted until new accept.
REQ-040 Grant switches 0->3 while buffer holds slave-0 beat, M_BREADY=0 -> slave-0 beat emitted first, then slave-3 beat.
